// File: rtl/wbs_cmd_resp_pkg.sv
// Shared types and default sizes for the Wishbone command/response slave.
// Read-back of the register bank is enabled by WBS_CMD_RESP_READBACK_EN.
package wbs_cmd_resp_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_RESP_DEPTH = 4;
    localparam int DROP_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        STALL = 2'd2
    } state_e;

endpackage

// File: rtl/wbs_resp_fifo.sv
// First-word-fall-through response FIFO; fullness comes from the
// registered count, so a same-cycle pop never makes room for a push.
module wbs_resp_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & (cnt_q != '0);
    assign dout_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/wbs_cmd_resp.sv
// Wishbone slave with a register bank and a tagged-write response stream.
// Define WBS_CMD_RESP_READBACK_EN to return register contents on reads.
module wbs_cmd_resp
    import wbs_cmd_resp_pkg::*;
#(
    parameter int WB_DATA_WIDTH = DEF_DATA_W,
    parameter int WB_ADDR_WIDTH = DEF_ADDR_W,
    parameter int RESP_DEPTH    = DEF_RESP_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WB_ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wbs_dat_i,
    output logic [WB_DATA_WIDTH-1:0] wbs_dat_o,
    input  logic                     wbs_we_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_tga_i,
    output logic                     wbs_ack_o,
    output logic                     reg_wr_stb,
    output logic [WB_ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [WB_DATA_WIDTH-1:0] reg_wr_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WB_ADDR_WIDTH-1:0] resp_addr,
    output logic [WB_DATA_WIDTH-1:0] resp_data,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;

    state_e                  state_q, state_d;
    logic [DW-1:0]           regs_q [2**AW];
    logic                    wr_stb_q;
    logic [AW-1:0]           wr_addr_q;
    logic [DW-1:0]           wr_data_q;
    logic [DROP_W-1:0]       drop_q;
    logic                    req, need_stall, commit, drop;
    logic                    wr_en, rd_en, push, pop, fifo_full;
    logic [AW+DW-1:0]        fifo_dout;
    logic [$clog2(RESP_DEPTH):0] fifo_cnt;

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign need_stall = wbs_we_i & wbs_tga_i & fifo_full;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = need_stall ? STALL : ACK;
            ACK:     state_d = IDLE;
            STALL: begin
                if (!wbs_stb_i)      state_d = IDLE;
                else if (!fifo_full) state_d = ACK;
            end
            default: state_d = IDLE;
        endcase
    end

    // A stalled request can only be a tagged write waiting for a slot.
    always_comb begin
        commit    = 1'b0;
        drop      = 1'b0;
        wbs_ack_o = (state_q == ACK);
        unique case (state_q)
            IDLE:    commit = req & ~need_stall;
            STALL: begin
                drop   = ~wbs_stb_i;
                commit = wbs_stb_i & ~fifo_full;
            end
            default: commit = 1'b0;
        endcase
    end

    assign wr_en = commit & wbs_we_i;
    assign rd_en = commit & ~wbs_we_i;
    assign push  = wr_en & wbs_tga_i;
    assign pop   = resp_valid & resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) regs_q[i] <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            drop_q    <= '0;
        end else begin
            wr_stb_q <= wr_en;
            if (wr_en) begin
                regs_q[wbs_adr_i] <= wbs_dat_i;
                wr_addr_q         <= wbs_adr_i;
                wr_data_q         <= wbs_dat_i;
            end
            if (drop && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign reg_wr_stb  = wr_stb_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign drop_cnt    = drop_q;

`ifdef WBS_CMD_RESP_READBACK_EN
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst)        rdata_q <= '0;
        else if (rd_en) rdata_q <= regs_q[wbs_adr_i];
    end

    assign wbs_dat_o = rdata_q;
`else
    assign wbs_dat_o = '0;
`endif

    wbs_resp_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   ({wbs_adr_i, wbs_dat_i}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    assign resp_valid = (fifo_cnt != '0);
    assign resp_addr  = fifo_dout[AW+DW-1:DW];
    assign resp_data  = fifo_dout[DW-1:0];

endmodule

// File: tb/tb_wbs_cmd_resp.sv
// Randomised and directed bench for wbs_cmd_resp against a queue-based
// transaction model; follows WBS_CMD_RESP_READBACK_EN like the design.
module tb_wbs_cmd_resp;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int DEPTH = 4;
`ifdef WBS_CMD_RESP_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] adr = '0;
    logic [DW-1:0] dat_i = '0;
    logic          we = 1'b0, stb = 1'b0, cyc = 1'b0, tga = 1'b0;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] wbs_dat_o, reg_wr_data, resp_data;
    logic [AW-1:0] reg_wr_addr, resp_addr;
    logic          wbs_ack_o, reg_wr_stb, resp_valid;
    logic [7:0]    drop_cnt;

    wbs_cmd_resp #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(wbs_dat_o),
        .wbs_we_i(we), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_tga_i(tga),
        .wbs_ack_o(wbs_ack_o),
        .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_addr(resp_addr), .resp_data(resp_data),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit rnd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: what the slave owes the master and the stream.
    logic [DW-1:0]    m_regs [2**AW];
    logic [AW+DW-1:0] m_q [$];
    int               m_drop;
    bit               m_ack, m_stall, m_rd, m_wstb;
    logic [AW-1:0]    m_waddr;
    logic [DW-1:0]    m_wdata, m_rdata;

    always @(posedge clk) begin
        bit full, pop, wr;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_q.delete();
            m_drop = 0; m_ack = 0; m_stall = 0; m_rd = 0; m_wstb = 0;
            m_rdata = '0;
        end else begin
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() != 0) && resp_ready;
            wr   = 0;
            if (m_ack) m_ack = 0;
            else if (m_stall) begin
                if (!stb) begin
                    m_stall = 0;
                    if (m_drop < 255) m_drop++;
                end else if (!full) begin
                    m_stall = 0; m_ack = 1; m_rd = 0; wr = 1;
                end
            end else if (cyc && stb) begin
                if (we && tga && full) m_stall = 1;
                else begin
                    m_ack = 1; m_rd = !we; wr = we;
                    if (!we) m_rdata = RB ? m_regs[adr] : '0;
                end
            end
            m_wstb = wr;
            if (wr) begin
                m_regs[adr] = dat_i; m_waddr = adr; m_wdata = dat_i;
            end
            if (pop) void'(m_q.pop_front());
            if (wr && tga) m_q.push_back({adr, dat_i});
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ack", wbs_ack_o, m_ack);
            chk("wr_stb", reg_wr_stb, m_wstb);
            if (m_wstb) begin
                chk("wr_addr", reg_wr_addr, m_waddr);
                chk("wr_data", reg_wr_data, m_wdata);
            end
            chk("resp_valid", resp_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("resp_head", {resp_addr, resp_data}, m_q[0]);
            chk("drop_cnt", drop_cnt, m_drop);
            if (m_ack && m_rd) chk("rdata", wbs_dat_o, m_rdata);
        end
    end

    // Called at a negedge; returns at the negedge where ack was seen or the limit hit.
    task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit t, input int limit,
                        output bit acked, output logic [DW-1:0] rd, output int n);
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d; tga = t;
        acked = 0; rd = '0; n = 0;
        while (n < limit && !acked) begin
            @(negedge clk);
            n++;
            if (rnd) resp_ready = 1'($urandom_range(0, 1));
            if (wbs_ack_o) begin
                acked = 1; rd = wbs_dat_o;
            end
        end
        cyc = 0; stb = 0;
    endtask

    task automatic drain(input int a0, input int cnt, input logic [DW-1:0] base, input string tag);
        resp_ready = 1;
        for (int k = 0; k < cnt; k++) begin
            chk({tag, "_valid"}, resp_valid, 1);
            chk({tag, "_addr"}, resp_addr, 64'(a0 + k));
            chk({tag, "_data"}, resp_data, base + DW'(a0 + k));
            @(negedge clk);
        end
        resp_ready = 0;
        chk({tag, "_empty"}, resp_valid, 0);
    endtask

    task automatic fill(input int a0, input logic [DW-1:0] base, input string tag);
        bit ak; logic [DW-1:0] rd; int n;
        for (int k = 0; k < DEPTH; k++) begin
            xfer(1, AW'(a0 + k), base + DW'(a0 + k), 1, 8, ak, rd, n);
            chk({tag, "_ack"}, ak, 1);
        end
    endtask

    initial begin
        bit ak; logic [DW-1:0] rd; int n;
        @(negedge clk);
        cmp_en = 1;
        chk("rst_ack", wbs_ack_o, 0);
        chk("rst_wr_stb", reg_wr_stb, 0);
        chk("rst_dat_o", wbs_dat_o, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 0;

        xfer(1, 6'h05, 32'hDEADBEEF, 0, 8, ak, rd, n);
        chk("w05_ack", ak, 1);
        chk("w05_latency", n, 1);
        chk("w05_stb", reg_wr_stb, 1);
        chk("w05_addr", reg_wr_addr, 6'h05);
        chk("w05_data", reg_wr_data, 32'hDEADBEEF);
        @(negedge clk);
        chk("w05_ack_one", wbs_ack_o, 0);
        chk("w05_stb_one", reg_wr_stb, 0);
        chk("w05_no_resp", resp_valid, 0);

        fill(1, 32'hA000_0000, "fill1");
        chk("fill1_valid", resp_valid, 1);
        drain(1, 4, 32'hA000_0000, "drain1");

        fill(8, 32'hB000_0000, "fill2");
        xfer(1, 6'h06, 32'h55, 1, 16, ak, rd, n);
        chk("tmo_noack", ak, 0);
        @(negedge clk);
        chk("tmo_drop", drop_cnt, 1);
        xfer(1, 6'h07, 32'h77, 0, 8, ak, rd, n);
        chk("tmo_idle_latency", n, 1);

        cyc = 1; stb = 1; we = 1; tga = 1; adr = 6'd12; dat_i = 32'hB000_000C;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("stall_ack_c%0d", c), wbs_ack_o, c == 5);
            resp_ready = (c == 3);
            if (c == 5) break;
        end
        cyc = 0; stb = 0;
        drain(9, 4, 32'hB000_0000, "drain2");

        xfer(1, 6'h3F, 32'h12345678, 0, 8, ak, rd, n);
        xfer(0, 6'h3F, 32'h0, 0, 8, ak, rd, n);
        chk("rd3f_ack", ak, 1);
        chk("rd3f_data", rd, RB ? 32'h12345678 : 32'h0);
        xfer(0, 6'h06, 32'h0, 1, 8, ak, rd, n);
        chk("rd06_data", rd, 0);

        fill(20, 32'hC000_0000, "fill3");
        cyc = 1; stb = 1; we = 1; tga = 1; adr = 6'd30; dat_i = 32'h30;
        repeat (3) @(negedge clk);
        rst = 1; cyc = 0; stb = 0;
        @(negedge clk);
        chk("rst_stall_ack", wbs_ack_o, 0);
        chk("rst_stall_valid", resp_valid, 0);
        chk("rst_stall_drop", drop_cnt, 0);
        rst = 0;
        xfer(1, 6'h01, 32'h1, 0, 8, ak, rd, n);
        chk("rst_stall_idle", n, 1);

        rnd = 1;
        repeat (300) begin
            xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(1, 12), ak, rd, n);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rnd = 0;
        resp_ready = 1;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
